// File: rtl/bits_readback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bits_readback_pkg
// Description : Shared constants and the saturating-increment helper used by
//               the bit-bus readback block and its per-bit channels.
// Revision    : 1.0 - initial release
// ============================================================================
package bits_readback_pkg;

  // Default build: four monitored bus bits, 16-bit transition counters.
  localparam int NBITS_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // Widest counter the helper supports. Channels zero-extend their counter
  // into this width, call sat_inc, then take back their own low bits.
  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic                 ovf;  // an event arrived while already saturated
    logic [CNT_MAX_W-1:0] cnt;  // counter value after the event
  } sat_res_t;

  // Saturating increment. With ev low the count passes through unchanged.
  // With ev high the count grows by one unless it already sits at max_val,
  // in which case it holds and ovf reports the lost event.
  function automatic sat_res_t sat_inc(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic [CNT_MAX_W-1:0] max_val,
    input logic                 ev
  );
    sat_res_t res;
    res.ovf = 1'b0;
    res.cnt = cnt;
    if (ev) begin
      if (cnt >= max_val) begin
        res.ovf = 1'b1;
      end else begin
        res.cnt = cnt + {{(CNT_MAX_W-1){1'b0}}, 1'b1};
      end
    end
    return res;
  endfunction

endpackage : bits_readback_pkg
`default_nettype wire

// File: rtl/bits_readback_chan.sv
`default_nettype none
// ============================================================================
// Module      : bits_readback_chan
// Description : One bit-bus readback channel. Tracks the previous sample, a
//               sticky change flag, a saturating transition counter and a
//               sticky lost-event flag, and freezes them into snapshot
//               registers when the shared read strobe fires.
// Ports       : clk_i        - system clock, rising edge
//               reset_n_i    - asynchronous active-low reset
//               primed_i     - high once the first post-reset sample is taken
//               read_stb_i   - one-cycle snapshot request
//               bit_i        - monitored bus bit, synchronous to clk_i
//               value_o      - snapshot of bit_i
//               change_o     - snapshot of sticky change flag
//               count_o      - snapshot of transition counter
//               overflow_o   - snapshot of counter-saturated-and-lost flag
// Revision    : 1.0 - initial release
// ============================================================================
module bits_readback_chan
  import bits_readback_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             primed_i,
  input  logic             read_stb_i,
  input  logic             bit_i,
  output logic             value_o,
  output logic             change_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  // All-ones value of a CNT_W-bit counter, expressed in helper width.
  localparam logic [CNT_MAX_W-1:0] CNT_SAT =
    CNT_MAX_W'((64'd1 << CNT_W) - 64'd1);

  logic             bits_q;
  logic             chg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic             ev;
  sat_res_t         sat;
  logic [CNT_W-1:0] cnt_next;

  // The previous sample is meaningless until primed, so the first level
  // seen after reset never reads as a transition.
  assign ev       = primed_i & (bit_i ^ bits_q);
  assign sat      = sat_inc(CNT_MAX_W'(cnt_q), CNT_SAT, ev);
  assign cnt_next = sat.cnt[CNT_W-1:0];

  // Saturation keeps the upper helper bits at zero; they are consumed here
  // only so that narrow builds leave no dangling signal.
  if (CNT_W < CNT_MAX_W) begin : g_hi_unused
    logic unused_hi;
    assign unused_hi = |sat.cnt[CNT_MAX_W-1:CNT_W];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bits_q <= 1'b0;
    end else begin
      bits_q <= bit_i;
    end
  end

  // Accumulators. A strobe hands the current-cycle event to the snapshot
  // and restarts from zero, so no event is both reported and carried.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      chg_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (read_stb_i) begin
      chg_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      chg_q <= chg_q | ev;
      cnt_q <= cnt_next;
      ovf_q <= ovf_q | sat.ovf;
    end
  end

  // Snapshot registers only move on a strobe and otherwise hold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      value_o    <= 1'b0;
      change_o   <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else if (read_stb_i) begin
      value_o    <= bit_i;
      change_o   <= chg_q | ev;
      count_o    <= cnt_next;
      overflow_o <= ovf_q | sat.ovf;
    end
  end

endmodule : bits_readback_chan
`default_nettype wire

// File: rtl/bits_readback.sv
`default_nettype none
// ============================================================================
// Module      : bits_readback
// Description : Samples bit-bus inputs back into register space. Each bit has
//               a level, a sticky change flag and a saturating transition
//               counter; a register read strobe freezes all of them into a
//               stable snapshot and clears the accumulators.
// Ports       : clk_i        - system clock, rising edge
//               reset_n_i    - asynchronous active-low reset
//               bits_i       - NBITS bus inputs, synchronous to clk_i
//               READ_RSTB    - one-cycle register read strobe
//               values_o     - snapshot of bits_i
//               changes_o    - snapshot of sticky change flags
//               counts_o     - snapshot of counters, bit i at [i*CNT_W +: CNT_W]
//               overflow_o   - snapshot of counter-saturated-and-lost flags
//               snap_valid_o - one-cycle pulse when the snapshot updates
// Revision    : 1.0 - initial release
// ============================================================================
module bits_readback
  import bits_readback_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [NBITS-1:0]       bits_i,
  input  logic                   READ_RSTB,
  output logic [NBITS-1:0]       values_o,
  output logic [NBITS-1:0]       changes_o,
  output logic [NBITS*CNT_W-1:0] counts_o,
  output logic [NBITS-1:0]       overflow_o,
  output logic                   snap_valid_o
);

  logic primed_q;

  // Goes high on the first clock after reset release and stays there; every
  // channel's previous-sample register is valid from then on.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= 1'b1;
    end
  end

  // Snapshot registers load on the edge after the strobe, so the valid pulse
  // is simply the strobe delayed by one cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      snap_valid_o <= 1'b0;
    end else begin
      snap_valid_o <= READ_RSTB;
    end
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_chan
    bits_readback_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .primed_i   (primed_q),
      .read_stb_i (READ_RSTB),
      .bit_i      (bits_i[i]),
      .value_o    (values_o[i]),
      .change_o   (changes_o[i]),
      .count_o    (counts_o[i*CNT_W +: CNT_W]),
      .overflow_o (overflow_o[i])
    );
  end

endmodule : bits_readback
`default_nettype wire

// File: tb/tb_bits_readback.sv
`default_nettype none
// ============================================================================
// Module      : tb_bits_readback
// Description : Self-checking bench for bits_readback. Drives a default
//               build (4 bits, 16-bit counters) and a narrow build (4 bits,
//               4-bit counters) through directed steps and a random run with
//               a per-bit edge-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bits_readback;

  logic        clk;
  logic        reset_n;

  logic [3:0]  bits;
  logic        strb;
  logic [3:0]  values;
  logic [3:0]  changes;
  logic [63:0] counts;
  logic [3:0]  ovf;
  logic        valid;

  logic [3:0]  bits4;
  logic        strb4;
  logic [3:0]  values4;
  logic [3:0]  changes4;
  logic [15:0] counts4;
  logic [3:0]  ovf4;
  logic        valid4;

  int n_assert = 0;
  int n_fail   = 0;

  bits_readback #(.NBITS(4), .CNT_W(16)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .bits_i       (bits),
    .READ_RSTB    (strb),
    .values_o     (values),
    .changes_o    (changes),
    .counts_o     (counts),
    .overflow_o   (ovf),
    .snap_valid_o (valid)
  );

  bits_readback #(.NBITS(4), .CNT_W(4)) dut4 (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .bits_i       (bits4),
    .READ_RSTB    (strb4),
    .values_o     (values4),
    .changes_o    (changes4),
    .counts_o     (counts4),
    .overflow_o   (ovf4),
    .snap_valid_o (valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          edges [4];
    int          sums  [4];
    logic [3:0]  nb;

    reset_n = 1'b0;
    bits    = 4'b0000;
    strb    = 1'b0;
    bits4   = 4'b0000;
    strb4   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edges[i] = 0;
      sums[i]  = 0;
    end

    // Reset state
    repeat (2) tick();
    check("rst_values",  64'(values),  64'h0);
    check("rst_changes", 64'(changes), 64'h0);
    check("rst_counts",  counts,       64'h0);
    check("rst_ovf",     64'(ovf),     64'h0);
    check("rst_valid",   64'(valid),   64'h0);

    // Static level 1010: priming must hide the initial level
    bits    = 4'b1010;
    reset_n = 1'b1;
    repeat (9) tick();
    strb = 1'b1;
    tick();
    strb = 1'b0;
    check("prime_valid",   64'(valid),   64'h1);
    check("prime_values",  64'(values),  64'ha);
    check("prime_changes", 64'(changes), 64'h0);
    check("prime_counts",  counts,       64'h0);
    tick();
    check("prime_valid_drop", 64'(valid), 64'h0);

    // Five edges on bit0, then back-to-back strobes
    for (int k = 0; k < 5; k++) begin
      bits[0] = ~bits[0];
      tick();
    end
    repeat (3) tick();
    strb = 1'b1;
    tick();
    check("tog_valid",   64'(valid),   64'h1);
    check("tog_counts",  counts,       64'h5);
    check("tog_changes", 64'(changes), 64'h1);
    check("tog_values",  64'(values),  64'hb);
    tick();
    strb = 1'b0;
    check("b2b_valid",   64'(valid),   64'h1);
    check("b2b_counts",  counts,       64'h0);
    check("b2b_changes", 64'(changes), 64'h0);
    tick();
    check("b2b_valid_drop", 64'(valid), 64'h0);

    // Edge on bit2 in the strobe cycle lands in that snapshot only
    bits[2] = 1'b1;
    strb    = 1'b1;
    tick();
    strb = 1'b0;
    check("same_changes", 64'(changes), 64'h4);
    check("same_counts",  counts,       64'h1_0000_0000);
    check("same_values",  64'(values),  64'hf);
    repeat (8) tick();
    check("hold_values", 64'(values), 64'hf);
    check("hold_valid",  64'(valid),  64'h0);
    strb = 1'b1;
    tick();
    strb = 1'b0;
    check("next_changes", 64'(changes), 64'h0);
    check("next_counts",  counts,       64'h0);

    // Narrow counter: exactly 15 edges fill it without loss
    for (int k = 0; k < 15; k++) begin
      bits4[1] = ~bits4[1];
      tick();
    end
    strb4 = 1'b1;
    tick();
    strb4 = 1'b0;
    check("sat15_counts", 64'(counts4), 64'h00f0);
    check("sat15_ovf",    64'(ovf4),    64'h0);
    tick();

    // 17 edges: saturates at 15 and flags the lost events
    for (int k = 0; k < 17; k++) begin
      bits4[1] = ~bits4[1];
      tick();
    end
    strb4 = 1'b1;
    tick();
    strb4 = 1'b0;
    check("sat17_counts",  64'(counts4),  64'h00f0);
    check("sat17_ovf",     64'(ovf4),     64'h2);
    check("sat17_changes", 64'(changes4), 64'h2);
    repeat (3) tick();
    strb4 = 1'b1;
    tick();
    strb4 = 1'b0;
    check("clean_ovf",    64'(ovf4),    64'h0);
    check("clean_counts", 64'(counts4), 64'h0);

    // Reset mid-accumulation discards three edges on bit3
    for (int k = 0; k < 3; k++) begin
      bits[3] = ~bits[3];
      tick();
    end
    reset_n = 1'b0;
    tick();
    check("midrst_values", 64'(values), 64'h0);
    check("midrst_counts", counts,      64'h0);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    strb = 1'b1;
    tick();
    strb = 1'b0;
    check("post_valid",   64'(valid),   64'h1);
    check("post_values",  64'(values),  64'h7);
    check("post_changes", 64'(changes), 64'h0);
    check("post_counts",  counts,       64'h0);
    check("post_ovf",     64'(ovf),     64'h0);

    // Random run: snapshot counts must sum to the edges driven
    for (int c = 0; c < 3000; c++) begin
      nb = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if (nb[i] != bits[i]) edges[i]++;
      end
      bits = nb;
      strb = ($urandom_range(0, 15) == 0);
      tick();
      check("rnd_valid", 64'(valid), 64'(strb));
      if (valid) begin
        for (int i = 0; i < 4; i++) sums[i] += int'(counts[i*16 +: 16]);
      end
    end
    strb = 1'b1;
    tick();
    strb = 1'b0;
    check("flush_valid", 64'(valid), 64'h1);
    for (int i = 0; i < 4; i++) sums[i] += int'(counts[i*16 +: 16]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rnd_sum%0d", i), 64'(sums[i]), 64'(edges[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_bits_readback
`default_nettype wire
